// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory-access stage with req/ack data bus and MEM/WB register
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_CHK_EN.
module mem_wb_stage #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          mwreg,
    input  logic          mm2reg,
    input  logic          mwmem,
    input  logic [DW-1:0] malu,
    input  logic [DW-1:0] mb,
    input  logic [RW-1:0] mrn,
    output logic          mem_stall,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          wwreg,
    output logic          wm2reg,
    output logic [DW-1:0] wmo,
    output logic [DW-1:0] walu,
    output logic [RW-1:0] wrn
`ifdef MEM_MISALIGN_CHK_EN
    ,
    output logic          misalign
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic          mem_op;
    logic          bad_addr;
    logic          start;
    logic [DW-1:0] latch;

    assign mem_op = mm2reg | mwmem;

`ifdef MEM_MISALIGN_CHK_EN
    assign bad_addr = mem_op & (malu[1:0] != 2'b00);
`else
    assign bad_addr = 1'b0;
`endif

    // A faulting access never reaches the bus, so it must not stall either.
    assign start = (state == IDLE) & mem_op & ~bad_addr;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                mem_stall = start;
                if (start) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                mem_stall = 1'b1;
                if (dmem_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            latch      <= '0;
            wwreg      <= 1'b0;
            wm2reg     <= 1'b0;
            wmo        <= '0;
            walu       <= '0;
            wrn        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= mwmem;
                        dmem_addr  <= malu;
                        dmem_wdata <= mb;
                        wwreg      <= 1'b0;
                        wm2reg     <= 1'b0;
                    end else if (mem_op) begin
                        wwreg  <= 1'b0;
                        wm2reg <= 1'b0;
                    end else begin
                        wwreg  <= mwreg;
                        wm2reg <= 1'b0;
                        walu   <= malu;
                        wrn    <= mrn;
                        wmo    <= '0;
                    end
                end
                REQ: begin
                    wwreg  <= 1'b0;
                    wm2reg <= 1'b0;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (!dmem_we) begin
                            latch <= dmem_rdata;
                        end
                    end
                end
                DONE: begin
                    // EX/MEM was held through the stall, so the op's fields are still present.
                    wwreg  <= mwreg & ~mwmem;
                    wm2reg <= mm2reg & ~mwmem;
                    walu   <= malu;
                    wmo    <= latch;
                    wrn    <= mrn;
                end
                default: begin
                    wwreg  <= 1'b0;
                    wm2reg <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_MISALIGN_CHK_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (state == IDLE) & bad_addr;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - self-checking bench for mem_wb_stage with a transaction-level memory model
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        clrn;
    logic        mwreg, mm2reg, mwmem;
    logic [31:0] malu, mb;
    logic [4:0]  mrn;
    logic        mem_stall, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        wwreg, wm2reg;
    logic [31:0] wmo, walu;
    logic [4:0]  wrn;
`ifdef MEM_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_pass  = 0;
    int n_total = 0;

    bit [31:0] model_mem [bit [31:0]];

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(32), .RW(5)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .mwmem      (mwmem),
        .malu       (malu),
        .mb         (mb),
        .mrn        (mrn),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .wwreg      (wwreg),
        .wm2reg     (wm2reg),
        .wmo        (wmo),
        .walu       (walu),
        .wrn        (wrn)
`ifdef MEM_MISALIGN_CHK_EN
        ,
        .misalign   (misalign)
`endif
    );

    // Presents one op, acts as the memory (ack after 'waits' extra REQ cycles), and
    // returns at 1 time unit after the edge that retires the op into MEM/WB.
    task automatic run_op(input logic wreg, input logic m2reg, input logic wmem,
                          input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rn,
                          input int waits, input logic [31:0] rdata,
                          output int stall_cnt, output logic req_first, output logic req_seen,
                          output logic req_we, output logic req_done,
                          output logic [31:0] req_addr, output logic [31:0] req_wdata,
                          output logic bub_ok, output logic timeout);
        int reqc;
        reqc = 0;
        mwreg = wreg; mm2reg = m2reg; mwmem = wmem; malu = alu; mb = b; mrn = rn;
        stall_cnt = 0; req_first = 1'b0; req_seen = 1'b0; req_we = 1'b0; req_done = 1'b0;
        req_addr = '0; req_wdata = '0; bub_ok = 1'b1; timeout = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (i == 0) req_first = dmem_req;
            if (mem_stall !== 1'b1) begin
                req_done = dmem_req;
                @(posedge clk);
                #1;
                timeout = 1'b0;
                break;
            end
            stall_cnt++;
            if (dmem_req === 1'b1) begin
                if (!req_seen) begin
                    req_seen  = 1'b1;
                    req_we    = dmem_we;
                    req_addr  = dmem_addr;
                    req_wdata = dmem_wdata;
                end
                reqc++;
                if (reqc == waits + 1) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            @(posedge clk);
            #1;
            dmem_ack = 1'b0;
            if (wwreg !== 1'b0 || wm2reg !== 1'b0) bub_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        clrn = 1'b0;
        mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
        dmem_ack = 0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn, mem_stall} !== '0)
            $display("FAIL reset_state: outputs=%h required all zero",
                     {dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn});
        else n_pass++;
        clrn = 1'b1;
    endtask

    task automatic test_reset_mid_access;
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h100; mb = 32'h77; mrn = 9;
        @(negedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if (dmem_req !== 1'b1) $display("FAIL rst_mid_req_active: dmem_req=%b required 1", dmem_req);
        else n_pass++;
        @(negedge clk);
        clrn = 1'b0;
        mwreg = 0; mm2reg = 0; malu = '0; mb = '0; mrn = '0;
        #1;
        n_total++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn} !== '0)
            $display("FAIL rst_mid_outputs: outputs=%h required all zero",
                     {dmem_req, dmem_we, dmem_addr, dmem_wdata, wwreg, wm2reg, wmo, walu, wrn});
        else n_pass++;
        @(posedge clk);
        #1;
        clrn = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_0000;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if (wwreg !== 1'b0 || wm2reg !== 1'b0 || wmo !== 32'h0 || dmem_req !== 1'b0 || mem_stall !== 1'b0)
            $display("FAIL rst_stale_ack: wwreg=%b wm2reg=%b wmo=%h req=%b stall=%b required all 0",
                     wwreg, wm2reg, wmo, dmem_req, mem_stall);
        else n_pass++;
    endtask

    task automatic test_alu;
        int sc; logic rf, rs, rw, rd, bo, to; logic [31:0] ra, rwd;
        run_op(1, 0, 0, 32'h0000_1234, 32'h0, 5'd7, 0, 32'h0, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || sc != 0 || rs !== 1'b0)
            $display("FAIL alu_stall: stall_cycles=%0d req=%b timeout=%b required 0/0/0", sc, rs, to);
        else n_pass++;
        n_total++;
        if (wwreg !== 1'b1 || wm2reg !== 1'b0 || walu !== 32'h1234 || wrn !== 5'd7 || wmo !== 32'h0)
            $display("FAIL alu_memwb: wwreg=%b wm2reg=%b walu=%h wrn=%0d wmo=%h required 1 0 1234 7 0",
                     wwreg, wm2reg, walu, wrn, wmo);
        else n_pass++;
    endtask

    task automatic test_load_wait;
        int sc; logic rf, rs, rw, rd, bo, to; logic [31:0] ra, rwd;
        run_op(1, 1, 0, 32'h40, 32'h0, 5'd3, 2, 32'hDEAD_BEEF, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || !rs || ra !== 32'h40 || rw !== 1'b0)
            $display("FAIL load_req: seen=%b addr=%h we=%b timeout=%b required 1 40 0 0", rs, ra, rw, to);
        else n_pass++;
        n_total++;
        if (sc != 4 || !bo || rd !== 1'b0)
            $display("FAIL load_stall: cycles=%0d bubbles_ok=%b req_in_done=%b required 4 1 0", sc, bo, rd);
        else n_pass++;
        n_total++;
        if (wwreg !== 1'b1 || wm2reg !== 1'b1 || wmo !== 32'hDEAD_BEEF || wrn !== 5'd3 || walu !== 32'h40)
            $display("FAIL load_memwb: wwreg=%b wm2reg=%b wmo=%h wrn=%0d walu=%h required 1 1 deadbeef 3 40",
                     wwreg, wm2reg, wmo, wrn, walu);
        else n_pass++;
    endtask

    task automatic test_store_zero_wait;
        int sc; logic rf, rs, rw, rd, bo, to; logic [31:0] ra, rwd;
        run_op(1, 0, 1, 32'h80, 32'h5555_AAAA, 5'd4, 0, 32'h0, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || !rs || rw !== 1'b1 || ra !== 32'h80 || rwd !== 32'h5555_AAAA)
            $display("FAIL store_req: seen=%b we=%b addr=%h wdata=%h required 1 1 80 5555aaaa", rs, rw, ra, rwd);
        else n_pass++;
        n_total++;
        if (sc != 2 || !bo)
            $display("FAIL store_stall: cycles=%0d bubbles_ok=%b required 2 1", sc, bo);
        else n_pass++;
        n_total++;
        if (wwreg !== 1'b0 || wm2reg !== 1'b0)
            $display("FAIL store_memwb: wwreg=%b wm2reg=%b required 0 0", wwreg, wm2reg);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        int sc; logic rf, rs, rw, rd, bo, to; logic [31:0] ra, rwd;
        run_op(1, 1, 0, 32'h200, 32'h0, 5'd10, 1, 32'h1111_2222, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || sc != 3 || wwreg !== 1'b1 || wmo !== 32'h1111_2222 || wrn !== 5'd10)
            $display("FAIL b2b_load: cycles=%0d wwreg=%b wmo=%h wrn=%0d required 3 1 11112222 10", sc, wwreg, wmo, wrn);
        else n_pass++;
        run_op(1, 0, 0, 32'hABCD, 32'h0, 5'd11, 0, 32'h0, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || sc != 0 || wwreg !== 1'b1 || wm2reg !== 1'b0 || walu !== 32'hABCD || wrn !== 5'd11)
            $display("FAIL b2b_alu: cycles=%0d wwreg=%b wm2reg=%b walu=%h wrn=%0d required 0 1 0 abcd 11",
                     sc, wwreg, wm2reg, walu, wrn);
        else n_pass++;
        run_op(1, 1, 0, 32'h300, 32'h0, 5'd12, 0, 32'h3333_0000, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        run_op(1, 1, 0, 32'h304, 32'h0, 5'd13, 0, 32'h3333_0004, sc, rf, rs, rw, rd, ra, rwd, bo, to);
        n_total++;
        if (to || rf !== 1'b0 || sc != 2 || wmo !== 32'h3333_0004 || wrn !== 5'd13)
            $display("FAIL b2b_load_load: req_first=%b cycles=%0d wmo=%h wrn=%0d required 0 2 33330004 13",
                     rf, sc, wmo, wrn);
        else n_pass++;
    endtask

    task automatic test_random;
        int sc; logic rf, rs, rw, rd, bo, to; logic [31:0] ra, rwd;
        for (int k = 0; k < 40; k++) begin
            int kind, waits, exp_stall;
            logic wreg, m2reg, wmem, is_mem, is_load;
            logic [31:0] alu, b, rdata;
            logic [4:0] rn;
            kind  = $urandom_range(0, 3);
            waits = $urandom_range(0, 3);
            wreg  = 1'($urandom_range(0, 1));
            m2reg = (kind == 1 || kind == 3);
            wmem  = (kind == 2 || kind == 3);
            alu   = $urandom;
            b     = $urandom;
            rn    = 5'($urandom);
            is_mem  = m2reg | wmem;
            is_load = m2reg & ~wmem;
`ifdef MEM_MISALIGN_CHK_EN
            if (is_mem) alu[1:0] = 2'b00;
`endif
            rdata = model_mem.exists(alu) ? model_mem[alu] : $urandom;
            if (is_load) model_mem[alu] = rdata;
            exp_stall = is_mem ? waits + 2 : 0;
            run_op(wreg, m2reg, wmem, alu, b, rn, waits, rdata, sc, rf, rs, rw, rd, ra, rwd, bo, to);
            if (wmem) model_mem[alu] = b;
            n_total++;
            if (to || sc != exp_stall || rs !== is_mem || !bo || rf !== 1'b0)
                $display("FAIL rnd%0d_stall: cycles=%0d req=%b bub=%b first=%b to=%b required %0d %b 1 0 0",
                         k, sc, rs, bo, rf, to, exp_stall, is_mem);
            else n_pass++;
            if (is_mem) begin
                n_total++;
                if (ra !== alu || rw !== wmem || (wmem && rwd !== b))
                    $display("FAIL rnd%0d_req: addr=%h we=%b wdata=%h required %h %b %h", k, ra, rw, rwd, alu, wmem, b);
                else n_pass++;
            end
            n_total++;
            if (wwreg !== (wreg & ~wmem) || wm2reg !== is_load || walu !== alu || wrn !== rn)
                $display("FAIL rnd%0d_ctrl: wwreg=%b wm2reg=%b walu=%h wrn=%0d required %b %b %h %0d",
                         k, wwreg, wm2reg, walu, wrn, wreg & ~wmem, is_load, alu, rn);
            else n_pass++;
            if (!wmem) begin
                n_total++;
                if (wmo !== (is_load ? rdata : 32'h0))
                    $display("FAIL rnd%0d_wmo: wmo=%h required %h", k, wmo, is_load ? rdata : 32'h0);
                else n_pass++;
            end
        end
    endtask

`ifdef MEM_MISALIGN_CHK_EN
    task automatic test_misalign;
        mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h42; mb = '0; mrn = 5'd5;
        @(negedge clk);
        n_total++;
        if (mem_stall !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL misalign_stall: stall=%b req=%b required 0 0", mem_stall, dmem_req);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if (misalign !== 1'b1 || wwreg !== 1'b0 || wm2reg !== 1'b0 || dmem_req !== 1'b0)
            $display("FAIL misalign_pulse: misalign=%b wwreg=%b wm2reg=%b req=%b required 1 0 0 0",
                     misalign, wwreg, wm2reg, dmem_req);
        else n_pass++;
        mwreg = 1; mm2reg = 0; malu = 32'h99; mrn = 5'd6;
        @(negedge clk);
        @(posedge clk);
        #1;
        n_total++;
        if (misalign !== 1'b0 || wwreg !== 1'b1 || walu !== 32'h99)
            $display("FAIL misalign_clear: misalign=%b wwreg=%b walu=%h required 0 1 99", misalign, wwreg, walu);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset;
        test_alu;
        test_load_wait;
        test_store_zero_wait;
        test_back_to_back;
        test_reset_mid_access;
`ifdef MEM_MISALIGN_CHK_EN
        test_misalign;
`endif
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
